hash_out_serializer: RTL and testbench
======================================

# hash_out_serializer

Byte-serial transmitter for the BLAKE2 digest, at the output end of the byte-serial I/O protocol. It captures the 512-bit chaining state from the core when the hash finishes, then streams the first `nn` bytes, least significant first, on the 8-bit output bus. The streamed bytes carry a valid flag and a last flag. It replaces the direct pass-through of `hash_i` onto `hash_o` in the I/O interface. It is the counterpart of the byte-serial receiver that loads `kk`/`nn`/`ll` and block data.

## Interface
Parameters:
- `NN_MAX`, 64: maximum digest length in bytes; sets the shift-register depth (`NN_MAX*8` bits).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `nreset`  in  1  synchronous, active-low reset.
- `nn_i`  in  7  digest length in bytes, sampled on capture.
- `h_v_i`  in  1  one-cycle pulse: `h_i` holds the final state.
- `h_i`  in  512  final state h[0..7]; byte k is `h_i[8k+7:8k]`.
- `ready_i`  in  1  downstream accepts a byte. Present only with `HASH_OUT_READY_EN`.
- `busy_o`  out  1  serializer is streaming; a capture now is dropped unless on the last handshake.
- `hash_v_o`  out  1  `hash_o` is valid.
- `hash_o`  out  8  current digest byte.
- `hash_last_o`  out  1  current byte is digest byte `nn-1`.

## Operation
- State machine with two states, IDLE and SEND.
- A handshake is defined as `hash_v_o & ready_i`. Without the macro, `ready_i` is tied to 1.
- Capture condition: `h_v_i` arrives while in IDLE, or in the same cycle as the handshake of the last byte.
- On capture:
  - shift register is loaded with `h_i`;
  - `nn_q` is loaded with the clamped `nn_i`;
  - `cnt_q` is set to 0;
  - state goes to SEND.
- Clamping of `nn_i`:
  - `nn_i > NN_MAX` is clamped to `NN_MAX`;
  - `nn_i == 0` is not captured; state stays IDLE and no output is produced.
- In SEND, each handshake:
  - shifts the register right by 8;
  - increments `cnt_q` (6 bits);
  - `hash_o` is always the register's low byte.
- `hash_last_o` is `hash_v_o & (cnt_q == nn_q-1)`.
- After the handshake on the last byte, state goes to IDLE, unless a capture happens in that same cycle.
- If `h_v_i` arrives in SEND outside the last-byte handshake, it is ignored. No state change.
- Output signals:
  - `hash_v_o` is high exactly in SEND;
  - `busy_o` is high in SEND.
- Without a handshake, `hash_o`, `hash_last_o` and `cnt_q` hold their values.

## Timing
- Reset values:
  - state is IDLE, `cnt_q`=0 and `nn_q`=0;
  - `hash_v_o`, `hash_last_o` and `busy_o` are 0;
  - `hash_o` is 0, because the shift register is cleared.
- Reset mid-stream aborts the stream. Outputs take their reset values in the cycle after `nreset` is sampled low.
- Latency: `h_v_i` at cycle t gives byte 0 with `hash_v_o`=1 at t+1. All outputs are registered.
- Throughput: with `ready_i` held at 1, byte k appears at t+1+k and the last byte at t+nn.
- A new capture on the last handshake gives a gapless stream: the next digest's byte 0 appears in the following cycle.
- `ready_i` low holds the current byte stable for any number of cycles.

## Configuration
- Macro: `HASH_OUT_READY_EN`.
- Defined: the `ready_i` port exists and the serializer honours backpressure as above.
- Undefined:
  - the port is absent and handshake is `hash_v_o` alone;
  - one byte is emitted per cycle with no stall;
  - the pin budget matches the existing output bus.

## Structure
- Shared package `blake2_pkg` holds:
  - `NN_MAX`;
  - the state enum (`S_IDLE`, `S_SEND`);
  - the byte-width constant;
  - the command encodings (`CMD_CONF`, `CMD_START`, `CMD_DATA`, `CMD_LAST`) shared with the receiver.
- One sub-module, `byte_shift_reg`, is natural: a parallel-load, shift-by-8-on-enable register of `NN_MAX*8` bits.
- FSM, counter and clamp logic live in the top module.

## Test plan
- Basic stream:
  - stimulus: `nn_i`=32, `h_i` byte k = k, `h_v_i` pulse at t, ready always high;
  - required: `hash_o` = 0x00..0x1F at t+1..t+32; `hash_last_o` only at t+32; `hash_v_o` low at t+33.
- Bounds:
  - stimulus: `nn_i`=1, then `nn_i`=100, then `nn_i`=0;
  - required: 1 byte with last set; 64 bytes (clamped); no output and `busy_o` stays 0.
- Back-to-back:
  - stimulus: second `h_v_i` (byte k = 0x80+k, nn=4) on the cycle of the first digest's last byte;
  - required: second stream's byte 0 = 0x80 in the next cycle, with no gap.
- Dropped capture:
  - stimulus: `h_v_i` at byte 5 of a 16-byte stream;
  - required: the stream completes unchanged and nothing follows it.
- Backpressure (with `HASH_OUT_READY_EN`):
  - stimulus: `ready_i` low for 3 cycles at byte 2;
  - required: byte 2 is held stable for 4 cycles and the total length is unchanged.
- Reset mid-stream:
  - stimulus: `nreset` low at byte 10;
  - required: next cycle all outputs are 0 and state is IDLE; a new capture afterwards streams normally from byte 0.

Source files
------------

// File: rtl/blake2_pkg.sv
// blake2_pkg: constants and types shared by the BLAKE2 byte-serial I/O blocks
// (hash_out_serializer and the byte-serial receiver).
//   NN_MAX         maximum digest length in bytes
//   BYTE_W         width of the byte-serial bus
//   state_e        serializer FSM states
//   cmd_e          receiver command encodings
package blake2_pkg;

  localparam int unsigned NN_MAX = 64;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_LAST  = 2'd3
  } cmd_e;

endpackage

// File: rtl/hash_out_serializer_byte_shift_reg.sv
// byte_shift_reg: parallel-load register of NBYTES bytes that shifts right by
// one byte on each enabled cycle; the low byte is presented on byte_o.
//   clk      clock, rising edge
//   nreset   synchronous active-low reset (clears the register)
//   load_i   parallel load of data_i (wins over shift_i)
//   shift_i  shift right by one byte, zero fill from the top
//   data_i   parallel load data
//   byte_o   current low byte
module byte_shift_reg #(
  parameter int unsigned NBYTES = blake2_pkg::NN_MAX
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [NBYTES*8-1:0]   data_i,
  output logic [7:0]            byte_o
);
  import blake2_pkg::*;

  logic [NBYTES*8-1:0] data_q;
  logic [NBYTES*8-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = data_q >> BYTE_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign byte_o = data_q[BYTE_W-1:0];

endmodule

// File: rtl/hash_out_serializer.sv
// hash_out_serializer: captures the final BLAKE2 chaining state and streams
// the first nn bytes, least significant first, on an 8-bit bus.
// Optional feature macro: HASH_OUT_READY_EN (adds ready_i backpressure;
// without it every valid cycle is a handshake).
//   clk          clock, rising edge
//   nreset       synchronous active-low reset
//   nn_i         digest length in bytes, sampled on capture (clamped to NN_MAX)
//   h_v_i        one-cycle pulse: h_i holds the final state
//   h_i          final state, byte k at h_i[8k+7:8k]
//   ready_i      downstream accepts a byte (HASH_OUT_READY_EN only)
//   busy_o       streaming in progress
//   hash_v_o     hash_o valid
//   hash_o       current digest byte
//   hash_last_o  current byte is byte nn-1
module hash_out_serializer #(
  parameter int unsigned NN_MAX = blake2_pkg::NN_MAX
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [6:0]   nn_i,
  input  logic         h_v_i,
  input  logic [511:0] h_i,
`ifdef HASH_OUT_READY_EN
  input  logic         ready_i,
`endif
  output logic         busy_o,
  output logic         hash_v_o,
  output logic [7:0]   hash_o,
  output logic         hash_last_o
);
  import blake2_pkg::state_e;
  import blake2_pkg::S_IDLE;
  import blake2_pkg::S_SEND;

  localparam logic [6:0] NN_MAX_L = 7'(NN_MAX);

  state_e     state_q, state_d;
  logic [6:0] nn_q, nn_d;
  logic [5:0] cnt_q, cnt_d;
  logic       hash_v_q, hash_v_d;
  logic       busy_q, busy_d;
  logic       hash_last_q, hash_last_d;

  logic       ready;
  logic       hs;
  logic       capture;
  logic [6:0] nn_clamp;

`ifdef HASH_OUT_READY_EN
  assign ready = ready_i;
`else
  assign ready = 1'b1;
`endif

  assign hs       = hash_v_q & ready;
  assign nn_clamp = (nn_i > NN_MAX_L) ? NN_MAX_L : nn_i;
  // A zero-length request is never captured. A capture is accepted while
  // idle or on the handshake of the last byte, giving a gapless restart.
  assign capture  = h_v_i && (nn_clamp != 7'd0) &&
                    ((state_q == S_IDLE) || (hs && hash_last_q));

  always_comb begin
    state_d = state_q;
    nn_d    = nn_q;
    cnt_d   = cnt_q;
    if (capture) begin
      state_d = S_SEND;
      nn_d    = nn_clamp;
      cnt_d   = '0;
    end else if (hs) begin
      cnt_d = cnt_q + 6'd1;
      if (hash_last_q) begin
        state_d = S_IDLE;
      end
    end
    // Outputs are computed from next state so they leave the flops aligned
    // with the state they describe.
    hash_v_d    = (state_d == S_SEND);
    busy_d      = (state_d == S_SEND);
    hash_last_d = (state_d == S_SEND) && ({1'b0, cnt_d} == (nn_d - 7'd1));
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      nn_q        <= '0;
      cnt_q       <= '0;
      hash_v_q    <= 1'b0;
      busy_q      <= 1'b0;
      hash_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nn_q        <= nn_d;
      cnt_q       <= cnt_d;
      hash_v_q    <= hash_v_d;
      busy_q      <= busy_d;
      hash_last_q <= hash_last_d;
    end
  end

  byte_shift_reg #(
    .NBYTES (NN_MAX)
  ) u_shift (
    .clk     (clk),
    .nreset  (nreset),
    .load_i  (capture),
    .shift_i (hs & ~capture),
    .data_i  (h_i[NN_MAX*8-1:0]),
    .byte_o  (hash_o)
  );

  assign hash_v_o    = hash_v_q;
  assign busy_o      = busy_q;
  assign hash_last_o = hash_last_q;

endmodule

// File: tb/tb_hash_out_serializer.sv
// tb_hash_out_serializer: randomized and directed stimulus for
// hash_out_serializer, checked every cycle against a byte-array model of the
// digest stream, plus directed stream-content checks.
module tb_hash_out_serializer;

  logic         clk = 1'b0;
  logic         nreset;
  logic [6:0]   nn_i;
  logic         h_v_i;
  logic [511:0] h_i;
  logic         ready_i;
  logic         busy_o;
  logic         hash_v_o;
  logic [7:0]   hash_o;
  logic         hash_last_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: the 64 captured bytes (plus a zero past the end), position of the
  // byte currently presented, stream length, and whether a stream is active.
  logic [7:0]  mb [0:64];
  int unsigned midx;
  int unsigned mlen;
  bit          mact;

  logic [7:0]  obs[$];
  int unsigned last_cnt;

  always #5 clk = ~clk;

  hash_out_serializer #(
    .NN_MAX (64)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .nn_i        (nn_i),
    .h_v_i       (h_v_i),
    .h_i         (h_i),
`ifdef HASH_OUT_READY_EN
    .ready_i     (ready_i),
`endif
    .busy_o      (busy_o),
    .hash_v_o    (hash_v_o),
    .hash_o      (hash_o),
    .hash_last_o (hash_last_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_h();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare outputs on the falling edge.
  task automatic step(input bit hv, input logic [6:0] nn, input logic [511:0] h,
                      input bit rdy, input bit rst_n);
    bit          rdy_eff;
    bit          hs;
    bit          lhs;
    bit          cap;
    int unsigned nc;
    nreset  = rst_n;
    h_v_i   = hv;
    nn_i    = nn;
    h_i     = h;
    ready_i = rdy;
`ifdef HASH_OUT_READY_EN
    rdy_eff = rdy;
`else
    rdy_eff = 1'b1;
`endif
    @(posedge clk);
    nc  = (nn > 7'd64) ? 64 : int'(nn);
    hs  = mact && rdy_eff;
    lhs = hs && (midx == mlen - 1);
    cap = hv && (nc != 0) && (!mact || lhs);
    if (!rst_n) begin
      mact = 1'b0;
      midx = 0;
      mlen = 0;
      for (int k = 0; k <= 64; k++) mb[k] = 8'h00;
    end else if (cap) begin
      for (int k = 0; k < 64; k++) mb[k] = h[8*k +: 8];
      mb[64] = 8'h00;
      mlen   = nc;
      midx   = 0;
      mact   = 1'b1;
    end else if (hs) begin
      midx++;
      if (midx == mlen) mact = 1'b0;
    end
    @(negedge clk);
    check("hash_v", 32'(hash_v_o), 32'(mact));
    check("busy", 32'(busy_o), 32'(mact));
    check("last", 32'(hash_last_o), 32'(mact && (midx == mlen - 1)));
    check("byte", 32'(hash_o), 32'(mb[midx]));
    if (hash_v_o === 1'b1) obs.push_back(hash_o);
    if (hash_last_o === 1'b1) last_cnt++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 7'd0, '0, 1'b1, 1'b1);
  endtask

  // Advance until the model presents byte `target` of the current stream.
  task automatic wait_idx(input int unsigned target);
    int unsigned n = 0;
    while (!(mact && midx == target) && n < 200) begin
      step(1'b0, 7'd0, '0, 1'b1, 1'b1);
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_obs();
    obs.delete();
    last_cnt = 0;
  endtask

  initial begin
    logic [511:0] h;
    logic [511:0] h2;
    mact = 1'b0;
    midx = 0;
    mlen = 0;
    for (int k = 0; k <= 64; k++) mb[k] = 8'h00;

    // Reset state
    repeat (3) step(1'b0, 7'd0, '0, 1'b1, 1'b0);
    check("rst_v", 32'(hash_v_o), 32'd0);
    check("rst_byte", 32'(hash_o), 32'd0);

    // Basic stream, nn=32, byte k = k
    for (int k = 0; k < 64; k++) h[8*k +: 8] = 8'(k);
    clear_obs();
    step(1'b1, 7'd32, h, 1'b1, 1'b1);
    check("basic_first_v", 32'(hash_v_o), 32'd1);
    check("basic_first_b", 32'(hash_o), 32'd0);
    idle(31);
    check("basic_last_at_t32", 32'(hash_last_o), 32'd1);
    check("basic_last_b", 32'(hash_o), 32'h1f);
    idle(1);
    check("basic_v_off_t33", 32'(hash_v_o), 32'd0);
    idle(5);
    check("basic_len", obs.size(), 32);
    check("basic_lastcnt", last_cnt, 1);
    for (int k = 0; k < 32; k++) if (k < obs.size()) check("basic_seq", 32'(obs[k]), k);

    // Bounds: nn=1, nn=100 (clamps to 64), nn=0 (nothing)
    clear_obs();
    step(1'b1, 7'd1, rand_h(), 1'b1, 1'b1);
    idle(4);
    check("nn1_len", obs.size(), 1);
    check("nn1_lastcnt", last_cnt, 1);
    clear_obs();
    step(1'b1, 7'd100, rand_h(), 1'b1, 1'b1);
    idle(70);
    check("nn100_len", obs.size(), 64);
    check("nn100_lastcnt", last_cnt, 1);
    clear_obs();
    step(1'b1, 7'd0, rand_h(), 1'b1, 1'b1);
    idle(4);
    check("nn0_len", obs.size(), 0);

    // Back-to-back: recapture on the last handshake of an 8-byte stream
    for (int k = 0; k < 64; k++) h2[8*k +: 8] = 8'(8'h80 + k);
    step(1'b1, 7'd8, rand_h(), 1'b1, 1'b1);
    wait_idx(7);
    clear_obs();
    step(1'b1, 7'd4, h2, 1'b1, 1'b1);
    check("b2b_v", 32'(hash_v_o), 32'd1);
    check("b2b_b0", 32'(hash_o), 32'h80);
    idle(8);
    check("b2b_len", obs.size(), 4);

    // Dropped capture at byte 5 of a 16-byte stream
    h = rand_h();
    clear_obs();
    step(1'b1, 7'd16, h, 1'b1, 1'b1);
    wait_idx(5);
    step(1'b1, 7'd4, rand_h(), 1'b1, 1'b1);
    idle(25);
    check("drop_len", obs.size(), 16);
    for (int k = 0; k < 16; k++) if (k < obs.size()) check("drop_seq", 32'(obs[k]), 32'(h[8*k +: 8]));

`ifdef HASH_OUT_READY_EN
    // Backpressure: ready low 3 cycles while byte 2 is presented
    h = rand_h();
    clear_obs();
    step(1'b1, 7'd8, h, 1'b1, 1'b1);
    wait_idx(2);
    repeat (3) step(1'b0, 7'd0, '0, 1'b0, 1'b1);
    idle(12);
    check("bp_len", obs.size(), 11);
    for (int k = 2; k < 6; k++) if (k < obs.size()) check("bp_hold", 32'(obs[k]), 32'(h[23:16]));
`endif

    // Reset mid-stream at byte 10, then a fresh stream
    step(1'b1, 7'd20, rand_h(), 1'b1, 1'b1);
    wait_idx(10);
    step(1'b0, 7'd0, '0, 1'b1, 1'b0);
    check("midrst_v", 32'(hash_v_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_byte", 32'(hash_o), 32'd0);
    h = rand_h();
    clear_obs();
    step(1'b1, 7'd3, h, 1'b1, 1'b1);
    idle(6);
    check("postrst_len", obs.size(), 3);
    if (obs.size() > 0) check("postrst_b0", 32'(obs[0]), 32'(h[7:0]));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          hv  = ($urandom_range(0, 5) == 0);
      logic [6:0]  nn  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                     : 7'($urandom_range(1, 10));
      bit          rdy = ($urandom_range(0, 3) != 0);
      bit          rn  = ($urandom_range(0, 99) != 0);
      step(hv, nn, rand_h(), rdy, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
